// File: rtl/duty_ctrl_if.sv
// Button inputs and duty outputs between duty_ctrl and its surroundings.
interface duty_ctrl_if;
    logic       btn_up_n;
    logic       btn_dn_n;
    logic [7:0] duty;
    logic       duty_valid;

    modport master (output btn_up_n, output btn_dn_n, input duty, input duty_valid);
    modport slave  (input btn_up_n, input btn_dn_n, output duty, output duty_valid);
endinterface

// File: rtl/duty_ctrl.sv
// Two-button PWM duty controller: synchronize, debounce, press/hold/auto-repeat
// per button, saturating duty update, both-button clear.
module duty_ctrl #(
    parameter int DEBOUNCE_TICKS     = 270000,
    parameter int REPEAT_DELAY_TICKS = 13500000,
    parameter int REPEAT_RATE_TICKS  = 2700000,
    parameter int STEP               = 10,
    parameter int DUTY_INIT          = 0
) (
    input  logic        clk,
    input  logic        rst,
    duty_ctrl_if.slave  bus
);
    localparam int DB_W   = $clog2(DEBOUNCE_TICKS) + 1;
    localparam int HOLD_W = (($clog2(REPEAT_DELAY_TICKS) > $clog2(REPEAT_RATE_TICKS)) ?
                             $clog2(REPEAT_DELAY_TICKS) : $clog2(REPEAT_RATE_TICKS)) + 1;

    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY_TICKS - 1);
    localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE_TICKS - 1);

    // state     | meaning
    // ST_IDLE   | accepted level released
    // ST_HOLD   | accepted pressed, counting to the auto-repeat delay
    // ST_REPEAT | auto-repeating, one step per repeat period
    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} state_t;

    // Index 0 is the up button, index 1 the down button; levels are raw polarity (1 = released).
    logic [1:0]        r_sync1;
    logic [1:0]        r_sync2;
    logic [1:0]        r_acc;
    logic [DB_W-1:0]   r_db_cnt   [2];
    state_t            r_state    [2];
    logic [HOLD_W-1:0] r_hold_cnt [2];
    logic [1:0]        r_req;
    logic              r_both_q;
    logic [7:0]        r_duty;
    logic              r_duty_valid;

    logic [1:0] w_pressed;
    logic       w_both;
    logic [8:0] w_sum;
    logic [7:0] w_up_val;
    logic [7:0] w_dn_val;
    logic [7:0] w_next;

    assign w_pressed = ~r_acc;
    assign w_both    = &w_pressed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
            r_acc   <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= {bus.btn_dn_n, bus.btn_up_n};
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_acc[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_acc[i]    <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // A held pair parks both FSMs in HOLD with a cleared count, so the survivor restarts its delay.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_state[i]    <= ST_IDLE;
                r_hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_req[i] <= 1'b0;
                if (!w_pressed[i]) begin
                    r_state[i]    <= ST_IDLE;
                    r_hold_cnt[i] <= '0;
                end else if (w_both) begin
                    r_state[i]    <= ST_HOLD;
                    r_hold_cnt[i] <= '0;
                end else begin
                    case (r_state[i])
                        ST_IDLE: begin
                            r_state[i]    <= ST_HOLD;
                            r_hold_cnt[i] <= '0;
                            r_req[i]      <= 1'b1;
                        end
                        ST_HOLD: begin
                            if (r_hold_cnt[i] == DELAY_LAST) begin
                                r_state[i]    <= ST_REPEAT;
                                r_hold_cnt[i] <= '0;
                                r_req[i]      <= 1'b1;
                            end else begin
                                r_hold_cnt[i] <= r_hold_cnt[i] + HOLD_W'(1);
                            end
                        end
                        ST_REPEAT: begin
                            if (r_hold_cnt[i] == RATE_LAST) begin
                                r_hold_cnt[i] <= '0;
                                r_req[i]      <= 1'b1;
                            end else begin
                                r_hold_cnt[i] <= r_hold_cnt[i] + HOLD_W'(1);
                            end
                        end
                        default: begin
                            r_state[i]    <= ST_IDLE;
                            r_hold_cnt[i] <= '0;
                        end
                    endcase
                end
            end
        end
    end

    // Clear wins over any step still in flight; simultaneous up and down cancel.
    always_comb begin
        w_sum    = {1'b0, r_duty} + 9'(STEP);
        w_up_val = w_sum[8] ? 8'hFF : w_sum[7:0];
        w_dn_val = (r_duty < 8'(STEP)) ? 8'h00 : (r_duty - 8'(STEP));
        w_next   = r_duty;
        if (w_both && !r_both_q) begin
            w_next = 8'(DUTY_INIT);
        end else if (r_req == 2'b01) begin
            w_next = w_up_val;
        end else if (r_req == 2'b10) begin
            w_next = w_dn_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_both_q     <= 1'b0;
            r_duty       <= 8'(DUTY_INIT);
            r_duty_valid <= 1'b0;
        end else begin
            r_both_q     <= w_both;
            r_duty       <= w_next;
            r_duty_valid <= (w_next != r_duty);
        end
    end

    assign bus.duty       = r_duty;
    assign bus.duty_valid = r_duty_valid;
endmodule

// File: tb/tb_duty_ctrl.sv
// Directed bench for duty_ctrl: expected duty updates are queued with their
// cycle when stimulus is applied and matched against each duty_valid pulse.
module tb_duty_ctrl;
    localparam int DB    = 4;
    localparam int DLY   = 20;
    localparam int RATE  = 5;
    localparam int STEPV = 10;

    typedef struct {
        int         t;
        logic [7:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_mis = 0;
    logic [7:0] prev_duty = 8'h00;
    logic [7:0] exp_duty = 8'h00;
    exp_t sb[$];

    duty_ctrl_if bus ();

    duty_ctrl #(
        .DEBOUNCE_TICKS     (DB),
        .REPEAT_DELAY_TICKS (DLY),
        .REPEAT_RATE_TICKS  (RATE),
        .STEP               (STEPV),
        .DUTY_INIT          (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_q) begin
            n_cmp++;
            if (bus.duty_valid) begin
                if (sb.size() == 0) begin
                    n_mis++;
                    $display("FAIL unexpected_pulse: cycle %0d duty %0d, no update expected", cyc, bus.duty);
                end else begin
                    e = sb.pop_front();
                    if (bus.duty !== e.d || cyc != e.t) begin
                        n_mis++;
                        $display("FAIL duty_update: got duty %0d at cycle %0d, expected %0d at cycle %0d",
                                 bus.duty, cyc, e.d, e.t);
                    end
                end
            end else if (bus.duty !== prev_duty) begin
                n_mis++;
                $display("FAIL silent_change: cycle %0d duty %0d -> %0d without duty_valid",
                         cyc, prev_duty, bus.duty);
            end
        end
        prev_duty = bus.duty;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_duty = 8'h00;
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    // Press one button for h cycles, queueing the steps the press must produce.
    task automatic hold_btn(input bit up, input int h);
        int         t0;
        int         k;
        int         t_step;
        logic [8:0] nxt;
        exp_t       e;
        @(negedge clk);
        if (up) bus.btn_up_n = 1'b0;
        else    bus.btn_dn_n = 1'b0;
        t0 = cyc + 1;
        k  = 0;
        t_step = t0 + DB + 3;
        while (t_step <= t0 + h + DB + 2) begin
            if (up) begin
                nxt = {1'b0, exp_duty} + 9'(STEPV);
                if (nxt > 9'd255) nxt = 9'd255;
            end else begin
                nxt = (exp_duty < 8'(STEPV)) ? 9'd0 : {1'b0, exp_duty - 8'(STEPV)};
            end
            if (nxt[7:0] != exp_duty) begin
                exp_duty = nxt[7:0];
                e.t = t_step;
                e.d = exp_duty;
                sb.push_back(e);
            end
            k++;
            t_step = (k == 1) ? t0 + DB + 3 + DLY : t0 + DB + 3 + DLY + RATE * (k - 1);
        end
        repeat (h) @(negedge clk);
        if (up) bus.btn_up_n = 1'b1;
        else    bus.btn_dn_n = 1'b1;
        repeat (DB + 8) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.duty !== 8'd0) begin
            n_mis++;
            $display("FAIL reset_duty: got %0d expected 0", bus.duty);
        end
        n_cmp++;
        if (bus.duty_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_valid: got %b expected 0", bus.duty_valid);
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (bus.duty !== 8'd0) begin
            n_mis++;
            $display("FAIL idle_duty: got %0d expected 0", bus.duty);
        end
    endtask

    task automatic test_single_press();
        do_reset();
        hold_btn(1'b1, 10);
        n_cmp++;
        if (sb.size() != 0) begin
            n_mis++;
            $display("FAIL single_missing: %0d updates outstanding, expected 0", sb.size());
        end
        n_cmp++;
        if (bus.duty !== 8'd10) begin
            n_mis++;
            $display("FAIL single_duty: got %0d expected 10", bus.duty);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.btn_up_n = 1'b0;
            @(negedge clk);
            @(negedge clk);
            bus.btn_up_n = 1'b1;
            @(negedge clk);
        end
        repeat (15) @(negedge clk);
        n_cmp++;
        if (bus.duty !== 8'd0) begin
            n_mis++;
            $display("FAIL bounce_duty: got %0d expected 0", bus.duty);
        end
    endtask

    task automatic test_auto_repeat();
        do_reset();
        hold_btn(1'b1, 60);
        n_cmp++;
        if (bus.duty !== 8'd90 || sb.size() != 0) begin
            n_mis++;
            $display("FAIL repeat60: got duty %0d outstanding %0d, expected 90 and 0", bus.duty, sb.size());
        end
        do_reset();
        hold_btn(1'b1, 160);
        n_cmp++;
        if (bus.duty !== 8'd255 || sb.size() != 0) begin
            n_mis++;
            $display("FAIL repeat_sat: got duty %0d outstanding %0d, expected 255 and 0", bus.duty, sb.size());
        end
    endtask

    task automatic test_floor();
        do_reset();
        hold_btn(1'b1, 10);
        hold_btn(1'b1, 10);
        hold_btn(1'b0, 40);
        n_cmp++;
        if (bus.duty !== 8'd0 || sb.size() != 0) begin
            n_mis++;
            $display("FAIL floor: got duty %0d outstanding %0d, expected 0 and 0", bus.duty, sb.size());
        end
    endtask

    task automatic test_both_buttons();
        int   t0;
        int   r;
        exp_t e;
        do_reset();
        for (int i = 0; i < 5; i++) hold_btn(1'b1, 10);
        n_cmp++;
        if (bus.duty !== 8'd50) begin
            n_mis++;
            $display("FAIL both_setup: got %0d expected 50", bus.duty);
        end
        @(negedge clk);
        bus.btn_up_n = 1'b0;
        t0 = cyc + 1;
        e.t = t0 + DB + 3; e.d = 8'd60; sb.push_back(e);
        e.t = t0 + DB + 5; e.d = 8'd0;  sb.push_back(e);
        repeat (3) @(negedge clk);
        bus.btn_dn_n = 1'b0;
        repeat (40) @(negedge clk);
        n_cmp++;
        if (bus.duty !== 8'd0 || sb.size() != 0) begin
            n_mis++;
            $display("FAIL both_clear: got duty %0d outstanding %0d, expected 0 and 0", bus.duty, sb.size());
        end
        bus.btn_dn_n = 1'b1;
        r = cyc + 1;
        e.t = r + DB + 2 + DLY;        e.d = 8'd10; sb.push_back(e);
        e.t = r + DB + 2 + DLY + RATE; e.d = 8'd20; sb.push_back(e);
        repeat (27) @(negedge clk);
        bus.btn_up_n = 1'b1;
        repeat (15) @(negedge clk);
        n_cmp++;
        if (bus.duty !== 8'd20 || sb.size() != 0) begin
            n_mis++;
            $display("FAIL both_release: got duty %0d outstanding %0d, expected 20 and 0", bus.duty, sb.size());
        end
    endtask

    task automatic test_reset_mid_repeat();
        int   t0;
        int   rr;
        exp_t e;
        do_reset();
        @(negedge clk);
        bus.btn_up_n = 1'b0;
        t0 = cyc + 1;
        for (int k = 0; k < 8; k++) begin
            e.t = (k == 0) ? t0 + DB + 3 : t0 + DB + 3 + DLY + RATE * (k - 1);
            e.d = 8'((k + 1) * STEPV);
            sb.push_back(e);
        end
        repeat (59) @(negedge clk);
        n_cmp++;
        if (bus.duty !== 8'd80 || sb.size() != 0) begin
            n_mis++;
            $display("FAIL pre_reset: got duty %0d outstanding %0d, expected 80 and 0", bus.duty, sb.size());
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rr = cyc;
        n_cmp++;
        if (bus.duty !== 8'd0 || bus.duty_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL mid_reset: got duty %0d valid %b, expected 0 and 0", bus.duty, bus.duty_valid);
        end
        e.t = rr + 1 + DB + 3; e.d = 8'd10; sb.push_back(e);
        repeat (12) @(negedge clk);
        bus.btn_up_n = 1'b1;
        repeat (15) @(negedge clk);
        n_cmp++;
        if (bus.duty !== 8'd10 || sb.size() != 0) begin
            n_mis++;
            $display("FAIL post_reset: got duty %0d outstanding %0d, expected 10 and 0", bus.duty, sb.size());
        end
    endtask

    initial begin
        bus.btn_up_n = 1'b1;
        bus.btn_dn_n = 1'b1;
        test_reset();
        test_single_press();
        test_bounce();
        test_auto_repeat();
        test_floor();
        test_both_buttons();
        test_reset_mid_repeat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/duty_ctrl.md
DUTY_CTRL -- requirements
Module: duty_ctrl

Interface
REQ-001 The block SHALL expose the following parameters, one per line: name, default, meaning.
- DEBOUNCE_TICKS, 270000, consecutive cycles a synchronized button level must hold before it is accepted (10 ms at 27 MHz).
- REPEAT_DELAY_TICKS, 13500000, cycles a button must be held after its accepted press before auto-repeat starts.
- REPEAT_RATE_TICKS, 2700000, cycles between auto-repeat steps.
- STEP, 10, duty increment/decrement per step, range 1..255.
- DUTY_INIT, 0, duty value after reset and after a both-button clear.
REQ-002 The block SHALL expose the following ports, one per line: name, direction, width, meaning.
- clk, input, 1, sole clock.
- rst, input, 1, reset; synchronous, active-high.
- btn_up_n, input, 1, raw asynchronous button, active-low, raises duty.
- btn_dn_n, input, 1, raw asynchronous button, active-low, lowers duty.
- duty, output, 8, PWM compare value fed to the downstream pwm stage.
- duty_valid, output, 1, one-cycle pulse on the cycle duty takes a new value.

Function
REQ-003 Each raw button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-004 Each button SHALL have a debounce counter that counts while the synchronized level differs from the accepted level and clears to 0 when they match.
REQ-005 The accepted level SHALL flip on the edge on which the counter would reach DEBOUNCE_TICKS; the counter then clears.
REQ-006 Each button SHALL run a 3-state FSM: IDLE (accepted released), HOLD (accepted pressed, counting to REPEAT_DELAY_TICKS), REPEAT (counting to REPEAT_RATE_TICKS, then restarting).
REQ-007 FSM transitions SHALL be as follows:
- IDLE->HOLD on an accepted press, emitting one step request.
- HOLD->REPEAT when the hold count reaches REPEAT_DELAY_TICKS, emitting one step request.
- In REPEAT, one step request each time the count reaches REPEAT_RATE_TICKS.
- Any state->IDLE on an accepted release, with no request.
REQ-008 An up request SHALL set duty to min(duty+STEP, 255), computed 9 bits wide; a down request SHALL set duty to max(duty-STEP, 0), computed signed or with a borrow check; wrap-around SHALL never occur.
REQ-009 Duty SHALL update on the clock edge after the request cycle, giving total latency of DEBOUNCE_TICKS+3 cycles from the first edge sampling a stable raw press.
REQ-010 When both buttons are accepted-pressed, duty SHALL be set to DUTY_INIT once, on the edge after the second button's acceptance.
REQ-011 While both buttons are accepted-pressed, both FSMs SHALL be held in HOLD with counters cleared, and no step requests SHALL be issued.
REQ-012 After one button of a held pair is released, the remaining button SHALL restart its HOLD count with no immediate step.
REQ-013 Up and down requests in the same cycle, when not covered by REQ-010, SHALL cancel, leaving duty unchanged.
REQ-014 duty_valid SHALL be 1 for exactly one cycle, coincident with the first cycle the new duty is visible, and only when the value actually changes; saturated steps and a clear to an equal value SHALL give no pulse.
REQ-015 All counters SHALL be sized with $clog2 of their parameter plus 1, so that no counter overflows at default values.

Reset
REQ-016 When rst=1 at a clock edge, the block SHALL set: duty=DUTY_INIT, duty_valid=0, synchronizers=1 (released), accepted levels=released, FSMs=IDLE, all counters=0.
REQ-017 A reset asserted mid-hold or mid-repeat SHALL abort the press; a button still held after reset SHALL be re-debounced and SHALL produce a fresh IDLE->HOLD step.

Verification (DEBOUNCE_TICKS=4, REPEAT_DELAY_TICKS=20, REPEAT_RATE_TICKS=5, STEP=10, DUTY_INIT=0)
REQ-018 The bench SHALL cover these directed scenarios:
- Single press: btn_up_n low for 10 cycles -> duty 0->10 exactly 7 cycles after the first low sample, with one duty_valid pulse.
- Bounce: btn_up_n toggling every 2 cycles for 20 cycles, then high -> duty stays 0 and no duty_valid pulse.
- Auto-repeat: btn_up_n held 60 cycles -> steps at press, at +20, then every 5 cycles, giving duty 0,10,20,...; saturates at 250 then 255 with no pulse past 255.
- Floor: duty=20, btn_dn_n held -> 10, 0, then repeated requests give duty 0 and no pulses.
- Both buttons: duty=50, up pressed then dn pressed 3 cycles later -> one up step to 60, then clear to 0; while both held, no steps.
- Reset mid-repeat: rst pulsed for 1 cycle while up is in REPEAT at duty=80 -> duty=0 next cycle; a continued hold gives 10 after DEBOUNCE_TICKS+3 cycles.
